// File: rtl/eq_result_accum_if.sv
// Stream bundle between the quadratic evaluator side and the block-result consumer.
// Sample side: in_valid/in_ready/in_z plus the flush pulse that closes a partial block.
// Result side: out_valid/out_ready with the block sum, max, min and sample count.
// The slave modport is the accumulator's view; master is the view of whoever drives it.
interface eq_result_accum_if #(
  parameter int unsigned Z_W   = 5,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned SUM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [Z_W-1:0]   in_z;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [Z_W-1:0]   out_max;
  logic [Z_W-1:0]   out_min;
  logic [CNT_W:0]   out_cnt;

  modport slave (
    input  in_valid, in_z, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_min, out_cnt
  );

  modport master (
    output in_valid, in_z, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_min, out_cnt
  );
endinterface

// File: rtl/eq_result_accum.sv
// Block accumulator for evaluator results z.
// Collects BLOCK_LEN samples (or fewer when flushed) and publishes their sum, max, min and count
// in registers that hold under backpressure. Only one block result is ever in flight.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset, discards any partial block and any held result
//   bus_io - slave view of eq_result_accum_if (sample stream in, block results out)
module eq_result_accum #(
  parameter int unsigned Z_W       = 5,
  parameter int unsigned BLOCK_LEN = 8,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned SUM_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  eq_result_accum_if.slave  bus_io
);

  typedef enum logic {StAccum, StHold} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
  logic [Z_W-1:0]   acc_max_q, acc_max_d;
  logic [Z_W-1:0]   acc_min_q, acc_min_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [Z_W-1:0]   out_max_q, out_max_d;
  logic [Z_W-1:0]   out_min_q, out_min_d;
  logic [CNT_W:0]   out_cnt_q, out_cnt_d;

  logic             in_ready;
  logic             acc;
  logic             close;
  logic [SUM_W-1:0] sum_nxt;
  logic [Z_W-1:0]   max_nxt;
  logic [Z_W-1:0]   min_nxt;
  logic [CNT_W:0]   cnt_nxt;

  // Accumulator values including this cycle's sample, if one is accepted.
  always_comb begin
    in_ready = (state_q == StAccum) ? 1'b1 : bus_io.out_ready;
    acc      = bus_io.in_valid & in_ready;
    sum_nxt  = acc_sum_q + (acc ? SUM_W'(bus_io.in_z) : '0);
    max_nxt  = (acc && (bus_io.in_z > acc_max_q)) ? bus_io.in_z : acc_max_q;
    min_nxt  = (acc && (bus_io.in_z < acc_min_q)) ? bus_io.in_z : acc_min_q;
    cnt_nxt  = {1'b0, count_q} + {{CNT_W{1'b0}}, acc};
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    acc_min_d   = acc_min_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_cnt_d   = out_cnt_q;
    close       = 1'b0;

    unique case (state_q)
      StAccum: begin
        // A flush on an empty block with no sample this cycle is a no-op.
        close = (acc && (count_q == LastIdx)) ||
                (bus_io.flush && ((count_q != '0) || acc));
        if (close) begin
          out_sum_d   = sum_nxt;
          out_max_d   = max_nxt;
          out_min_d   = min_nxt;
          out_cnt_d   = cnt_nxt;
          out_valid_d = 1'b1;
          count_d     = '0;
          acc_sum_d   = '0;
          acc_max_d   = '0;
          acc_min_d   = '1;
          state_d     = StHold;
        end else if (acc) begin
          count_d   = cnt_nxt[CNT_W-1:0];
          acc_sum_d = sum_nxt;
          acc_max_d = max_nxt;
          acc_min_d = min_nxt;
        end
      end
      StHold: begin
        // Accumulators are at their cleared values here, so a sample accepted while the
        // result is being taken simply becomes the first sample of the next block.
        if (bus_io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAccum;
          if (acc) begin
            count_d   = cnt_nxt[CNT_W-1:0];
            acc_sum_d = sum_nxt;
            acc_max_d = max_nxt;
            acc_min_d = min_nxt;
          end
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StAccum;
      count_q     <= '0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_min_q   <= '1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_min_q   <= acc_min_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign bus_io.in_ready  = in_ready;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_sum   = out_sum_q;
  assign bus_io.out_max   = out_max_q;
  assign bus_io.out_min   = out_min_q;
  assign bus_io.out_cnt   = out_cnt_q;

endmodule
